// File: rtl/anti_theft_pkg.sv
// rtl/anti_theft_pkg.sv - shared interval codes and scheduler state type
package anti_theft_pkg;

    localparam logic [1:0] INT_ARM    = 2'b00;
    localparam logic [1:0] INT_DRIVER = 2'b01;
    localparam logic [1:0] INT_PASS   = 2'b10;
    localparam logic [1:0] INT_ALARM  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        GUARD,
        WAIT
    } sched_state_t;

endpackage

// File: rtl/fixed_prio_pick.sv
// rtl/fixed_prio_pick.sv - lowest-index-first one-hot picker with index output
module fixed_prio_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// rtl/timer_scheduler.sv - shares one countdown timer among N_REQ fixed-priority requesters
// Optional PREEMPT_EN: a lower-index request aborts the running owner while in WAIT.
module timer_scheduler
    import anti_theft_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 0,
    parameter int TO_W        = 24
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   req_interval,
    input  logic                 expired,
    output logic [1:0]           interval,
    output logic                 start_timer,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     abort,
    output logic                 busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam bit WD_EN = (TIMEOUT_CYC > 0);
    localparam logic [TO_W-1:0] TO_LAST = WD_EN ? TO_W'(TIMEOUT_CYC - 1) : '0;

    sched_state_t      state, state_nxt;
    logic [TO_W-1:0]   wd_cnt;
    logic [N_REQ-1:0]  pick_in, pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              load_new, start_nxt, timeout_hit;
    logic [N_REQ-1:0]  done_nxt, abort_nxt;

    // Outside WAIT the picker arbitrates all requests; in WAIT it only sees
    // requesters of higher priority than the owner (grant - 1 masks them).
`ifdef PREEMPT_EN
    assign pick_in = (state == WAIT) ? (req & (grant - N_REQ'(1))) : req;
`else
    assign pick_in = req;
`endif

    fixed_prio_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req    (pick_in),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign timeout_hit = WD_EN && (wd_cnt == TO_LAST);
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt = state;
        load_new  = 1'b0;
        start_nxt = 1'b0;
        done_nxt  = '0;
        abort_nxt = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    load_new  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD:  state_nxt = START;
            START: begin
                start_nxt = 1'b1;
                state_nxt = GUARD;
            end
            GUARD: state_nxt = WAIT;
            WAIT: begin
                if (expired) begin
                    done_nxt  = grant;
                    state_nxt = IDLE;
                end else if (!(|(req & grant))) begin
                    state_nxt = IDLE;
`ifdef PREEMPT_EN
                end else if (pick_any) begin
                    abort_nxt = grant;
                    load_new  = 1'b1;
                    state_nxt = LOAD;
`endif
                end else if (timeout_hit) begin
                    abort_nxt = grant;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            interval    <= INT_ARM;
            start_timer <= 1'b0;
            done        <= '0;
            abort       <= '0;
            wd_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            start_timer <= start_nxt;
            done        <= done_nxt;
            abort       <= abort_nxt;
            if (load_new) begin
                grant    <= pick_onehot;
                interval <= req_interval[2*int'(pick_idx) +: 2];
            end else if (state_nxt == IDLE) begin
                grant    <= '0;
            end
            // Counts consecutive WAIT cycles; any exit (including preemption) restarts at 0.
            if (state == WAIT && state_nxt == WAIT) begin
                wd_cnt <= wd_cnt + TO_W'(1);
            end else begin
                wd_cnt <= '0;
            end
        end
    end

endmodule
